// File: rtl/gate_lattice_pipe.sv
// gate_lattice_pipe: lane-wise selectable 2-input logic op feeding an elastic
// DEPTH-stage valid/ready pipeline, with an XOR signature and saturating beat count.
module gate_lattice_pipe #(
  parameter int W     = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [NCH*W-1:0] a,
  input  logic [NCH*W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] y,
  input  logic             acc_clr,
  output logic [W-1:0]     acc,
  output logic [15:0]      cnt
);

  localparam int BW = NCH * W;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOTA  = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  function automatic logic [W-1:0] laneOp(input logic [2:0] sel,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] z);
    case (op_e'(sel))
      OP_AND:  laneOp = x & z;
      OP_OR:   laneOp = x | z;
      OP_XOR:  laneOp = x ^ z;
      OP_NOTA: laneOp = ~x;
      OP_NAND: laneOp = ~(x & z);
      OP_NOR:  laneOp = ~(x | z);
      OP_XNOR: laneOp = ~(x ^ z);
      default: laneOp = x;
    endcase
  endfunction

  logic [BW-1:0]    opResult;
  logic [DEPTH-1:0] stageValid_q;
  logic [BW-1:0]    stageData_q [DEPTH];
  logic [DEPTH-1:0] stageLoad;
  logic [W-1:0]     foldR;
  logic             outFire;
  logic [W-1:0]     acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;

  always_comb begin
    opResult = '0;
    for (int c = 0; c < NCH; c++) begin
      opResult[c*W +: W] = laneOp(op, a[c*W +: W], b[c*W +: W]);
    end
  end

  // Ready ripples back from the output: a stage may load when it is empty or
  // when its own beat is moving on this cycle.
  always_comb begin : readyChain
    logic downOk;
    logic adv;
    downOk    = out_ready;
    adv       = 1'b0;
    stageLoad = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv          = stageValid_q[k] && downOk;
      stageLoad[k] = !stageValid_q[k] || adv;
      downOk       = stageLoad[k];
    end
  end

  assign in_ready = stageLoad[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stageData_q[k] <= '0;
      end
    end else begin
      if (stageLoad[0]) begin
        stageValid_q[0] <= in_valid;
        if (in_valid) begin
          stageData_q[0] <= opResult;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (stageLoad[k]) begin
          stageValid_q[k] <= stageValid_q[k-1];
          if (stageValid_q[k-1]) begin
            stageData_q[k] <= stageData_q[k-1];
          end
        end
      end
    end
  end

  // y is pulled to zero whenever no beat is being presented.
  assign out_valid = stageValid_q[DEPTH-1];
  assign y         = out_valid ? stageData_q[DEPTH-1] : '0;
  assign outFire   = out_valid && out_ready;

  always_comb begin
    foldR = '0;
    for (int c = 0; c < NCH; c++) begin
      foldR = foldR ^ y[c*W +: W];
    end
  end

  // A clear coinciding with a delivery keeps only the delivered beat's fold.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = outFire ? foldR : '0;
    end else if (outFire) begin
      acc_d = acc_q ^ foldR;
    end
    cnt_d = cnt_q;
    if (outFire && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;
  assign cnt = cnt_q;

endmodule

// File: tb/tb_gate_lattice_pipe.sv
// tb_gate_lattice_pipe: drives directed and random beats into gate_lattice_pipe and
// compares every cycle against a queue-based behavioural model.
module tb_gate_lattice_pipe;

  localparam int W     = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 2;
  localparam int BW    = NCH * W;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          acc_clr   = 1'b0;
  logic [2:0]    op        = 3'd0;
  logic [BW-1:0] a         = '0;
  logic [BW-1:0] b         = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] y;
  logic [W-1:0]  acc;
  logic [15:0]   cnt;

  int total = 0;
  int bad   = 0;

  gate_lattice_pipe #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .acc_clr(acc_clr), .acc(acc), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    int            acceptCycle;
  } beat_t;

  beat_t         modelQ [$];
  logic [W-1:0]  accM;
  int            cntM;
  int            lastDepart;
  int            cycleNow  = 0;
  int            delivered = 0;
  logic [BW-1:0] capY [$];
  int            capCyc [$];

  logic [31:0] sweepExp [8] = '{32'h0F00A005, 32'hFFF0FA5F, 32'hF0F05A5A, 32'hF00F55AA,
                                32'hF0FF5FFA, 32'h000F05A0, 32'h0F0FA5A5, 32'h0FF0AA55};

  // Truth-table view of each op: bit {a,b} of the table is the output bit.
  function automatic logic [BW-1:0] modelOp(input logic [2:0] o, input logic [BW-1:0] x,
                                            input logic [BW-1:0] z);
    logic [3:0] tt;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0011;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < BW; i++) modelOp[i] = tt[{x[i], z[i]}];
  endfunction

  function automatic logic [W-1:0] foldLanes(input logic [BW-1:0] d);
    foldLanes = '0;
    for (int c = 0; c < NCH; c++) foldLanes = foldLanes ^ d[c*W +: W];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [BW-1:0] x,
                               input logic [BW-1:0] z, input logic rdy, input logic clr);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = z;
    out_ready = rdy;
    acc_clr   = clr;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Beat i becomes visible DEPTH cycles after acceptance, but never before the
  // cycle after its predecessor left.
  always @(negedge clk) begin : scoreboard
    logic          expValid;
    logic          expInReady;
    logic [BW-1:0] expY;
    logic [W-1:0]  r;
    beat_t         bt;
    cycleNow++;
    if (rst) begin
      modelQ.delete();
      accM       = '0;
      cntM       = 0;
      lastDepart = -100;
      delivered  = 0;
    end
    expValid = 1'b0;
    if (modelQ.size() > 0) begin
      expValid = (cycleNow >= modelQ[0].acceptCycle + DEPTH) && (cycleNow >= lastDepart + 1);
    end
    expInReady = !((modelQ.size() == DEPTH) && !out_ready);
    expY       = expValid ? modelQ[0].data : '0;
    checkOutput("out_valid", 32'(out_valid), 32'(expValid));
    checkOutput("y", y, expY);
    checkOutput("in_ready", 32'(in_ready), 32'(expInReady));
    checkOutput("acc", 32'(acc), 32'(accM));
    checkOutput("cnt", 32'(cnt), 32'(cntM));
    if (!rst) begin
      if (out_valid && out_ready) begin
        capY.push_back(y);
        capCyc.push_back(cycleNow);
      end
      r = '0;
      if (expValid && out_ready) begin
        bt         = modelQ.pop_front();
        r          = foldLanes(bt.data);
        lastDepart = cycleNow;
        delivered++;
        if (cntM < 65535) cntM++;
      end
      if (acc_clr) accM = (expValid && out_ready) ? r : '0;
      else accM = accM ^ r;
      if (in_valid && expInReady) begin
        bt.data        = modelOp(op, a, b);
        bt.acceptCycle = cycleNow;
        modelQ.push_back(bt);
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int guard;
    logic [BW-1:0] yHold;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_y", y, 32'd0);
    checkOutput("reset_acc_cnt", {8'h0, acc, cnt}, 32'd0);

    // Basic AND beat
    applyStimulus(1'b1, 3'd0, 32'h08040201, 32'hFFFFFFFF, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("basic_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("basic_lat2_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_y", y, 32'h08040201);
    tick();
    checkOutput("basic_acc", 32'(acc), 32'h0F);
    checkOutput("basic_cnt", 32'(cnt), 32'd1);

    // All ops back-to-back
    doReset();
    base = capY.size();
    for (int o = 0; o < 8; o++) begin
      applyStimulus(1'b1, 3'(o), 32'h0FF0AA55, 32'hFF00F00F, 1'b1, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    checkOutput("sweep_count", 32'(capY.size() - base), 32'd8);
    if (capY.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("sweep_y%0d", i), capY[base+i], sweepExp[i]);
        checkOutput($sformatf("sweep_cyc%0d", i), 32'(capCyc[base+i] - capCyc[base]), 32'(i));
      end
    end
    checkOutput("sweep_cnt", 32'(cnt), 32'd8);
    checkOutput("sweep_acc", 32'(acc), 32'h00);

    // acc_clr alone and colliding with a delivery
    doReset();
    applyStimulus(1'b1, 3'd7, 32'h0000003C, 32'h0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("clr_pre_acc", 32'(acc), 32'h3C);
    applyStimulus(1'b1, 3'd7, 32'h00000081, 32'h0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("clr_beat_waiting", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    acc_clr   = 1'b1;
    tick();
    out_ready = 1'b0;
    acc_clr   = 1'b0;
    checkOutput("clr_collide_acc", 32'(acc), 32'h81);
    checkOutput("clr_collide_cnt", 32'(cnt), 32'd2);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    checkOutput("clr_alone_acc", 32'(acc), 32'h00);
    checkOutput("clr_alone_cnt", 32'(cnt), 32'd2);

    // Backpressure: two beats fill the pipe, the third waits
    doReset();
    base = capY.size();
    applyStimulus(1'b1, 3'd7, 32'h11111111, 32'h0, 1'b0, 1'b0);
    tick();
    a = 32'h22222222;
    tick();
    a = 32'h33333333;
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    yHold = y;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_in_ready_hold", 32'(in_ready), 32'd0);
      checkOutput("bp_y_stable", y, yHold);
    end
    checkOutput("bp_y_head", y, 32'h11111111);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checkOutput("bp_count", 32'(capY.size() - base), 32'd3);
    if (capY.size() - base == 3) begin
      checkOutput("bp_order0", capY[base], 32'h11111111);
      checkOutput("bp_order1", capY[base+1], 32'h22222222);
      checkOutput("bp_order2", capY[base+2], 32'h33333333);
      checkOutput("bp_consecutive", 32'(capCyc[base+2] - capCyc[base]), 32'd2);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tick();
    end
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
    repeat (5) tick();

    // Reset with two beats in flight
    applyStimulus(1'b1, 3'd7, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    tick();
    a = 32'h5A5A5A5A;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_y", y, 32'd0);
    checkOutput("mid_rst_acc", 32'(acc), 32'd0);
    checkOutput("mid_rst_cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_post_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) tick();
    checkOutput("mid_no_stale", 32'(out_valid), 32'd0);

    // Saturation of the beat counter
    guard = 0;
    while (delivered < 65537 && guard < 70000) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1, 1'b0);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    repeat (4) tick();
    checkOutput("sat_reached", 32'(delivered >= 65537), 32'd1);
    checkOutput("sat_cnt", 32'(cnt), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_lattice_pipe.md
Name: gate_lattice_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit gate-primitive blocks.
- Applies a selectable 2-input logic op lane-wise across NCH channels of W-bit operands.
- Carries results through a DEPTH-stage elastic pipeline with valid/ready handshakes.
- Keeps a running XOR signature and a saturating transaction count, for use as a datapath-lattice checker inside the fuzz-generated gate netlists.

Parameters:
W, 8, bit width of each channel operand (>=1)
NCH, 4, number of channels (>=1)
DEPTH, 2, pipeline stages between input handshake and output (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input beat
op  input  3  operation select, sampled with input beat
a  input  NCH*W  operand A; channel c at bits [c*W +: W]
b  input  NCH*W  operand B; same packing
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output beat
y  output  NCH*W  result; same packing
acc_clr  input  1  synchronous clear of acc
acc  output  W  running XOR signature of delivered results
cnt  output  16  count of delivered output beats, saturating

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all stage data 0, out_valid=0, y=0, acc=0, cnt=0. in_ready=1 in the first cycle after release. Reset mid-flight discards all in-flight beats; there is no partial delivery.
- Op encoding, per channel c, bitwise on a_c and b_c:
  - 0 AND, 1 OR, 2 XOR, 3 NOT a_c (b ignored)
  - 4 NAND, 5 NOR, 6 XNOR
  - 7 pass a_c unchanged
- The op result is computed combinationally at input and registered into stage 0. op, a and b are not held after acceptance.
- Input handshake: a beat transfers when in_valid && in_ready.
- Pipeline is elastic, one valid bit per stage.
  - Stage k loads from stage k-1 when stage k is empty or is itself advancing.
  - in_ready = !v0 || stage0 advancing.
  - Combinational ready path is permitted; no bubbles under continuous flow.
- Latency: exactly DEPTH cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- Backpressure: the pipeline holds up to DEPTH beats. When full and out_ready=0, in_ready=0. Data and order are preserved, and y stays stable while out_valid && !out_ready.
- y equals the last-stage data when out_valid=1, and is forced to all-zero when out_valid=0 (pull-down semantics).
- Signature: on each output handshake (out_valid && out_ready), acc <= acc ^ R, where R = XOR over all channels of the delivered y_c (W bits).
- acc_clr:
  - acc_clr alone: acc <= 0.
  - acc_clr with a simultaneous output handshake: acc <= R (clear, then fold).
  - acc_clr does not affect cnt or the pipeline.
- cnt increments by 1 per output handshake and saturates at 16'hFFFF (no wrap).
- Simultaneous input and output handshakes in the same cycle are both honoured. Occupancy is unchanged.
- All outputs are driven from registers except in_ready and the zero-gating of y.

Test Plan:
- Basic op, W=8/NCH=4/DEPTH=2: a channels {0x08,0x04,0x02,0x01} (a=0x08040201), b=0xFFFFFFFF, op=0 (AND), one beat, out_ready=1 -> out_valid high exactly 2 cycles after accept, y=0x08040201, acc=0x0F, cnt=1.
- All ops sweep: a=0x0FF0AA55, b=0xFF00F00F, ops 0..7 back-to-back. Required results:
  - AND 0x0F00A005, OR 0xFFF0FA5F, XOR 0xF0F05A5A, NOT 0xF00F55AA
  - NAND 0xF0FF5FFA, NOR 0x000F05A0, XNOR 0x0F0FA5A5, pass 0x0FF0AA55
  - 8 consecutive out_valid cycles; acc and cnt=8 match the model.
- Backpressure: out_ready=0, present 3 beats -> in_ready falls after 2 accepts. The 3rd beat is held by the source; y is stable and zero-free while out_valid. Raising out_ready delivers all 3 in order on consecutive cycles.
- acc_clr collision: acc=0x3C, deliver a beat with R=0x81 while acc_clr=1 -> acc=0x81 next cycle. acc_clr alone -> acc=0x00, cnt unchanged.
- Reset mid-flight: 2 beats in pipeline, assert rst asynchronously between edges -> out_valid, y, acc and cnt are 0 immediately. After release, no stale beats emerge and in_ready=1.
- Saturation: deliver 65537 beats -> cnt=0xFFFF after beat 65535 and remains 0xFFFF; acc continues to update.
